// File: rtl/aes_key_expander.sv
// AES key-schedule engine: expands a 128/192/256-bit key into a round-key store, one word per clock.
// Latency: done pulses 40/46/52 cycles after the start edge; start is ignored while busy.
// Backpressure: none. Optional KEYEXP_ZEROIZE_EN adds a zeroize input that wipes the store and aborts.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   assign y = SBOX[{a, 3'b000} +: 8];
endmodule

module aes_key_expander #(
   parameter int MAX_KEY_BITS = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
`ifdef KEYEXP_ZEROIZE_EN
   input  logic                    zeroize,
`endif
   input  logic                    start,
   input  logic [1:0]              key_mode,
   input  logic [MAX_KEY_BITS-1:0] key_in,
   output logic                    busy,
   output logic                    done,
   output logic                    key_valid,
   output logic                    err,
   input  logic [3:0]              rd_round,
   output logic [127:0]            rd_key
);
   localparam int MAX_NK    = MAX_KEY_BITS / 32;
   localparam int MAX_WORDS = 4 * (MAX_NK + 7);

   typedef enum logic {IDLE, EXPAND} state_t;

   state_t      state;
   logic [31:0] w [MAX_WORDS];
   logic [5:0]  idx, last;
   logic [3:0]  nk, nr, pos;
   logic [7:0]  rcon, rcon_next;
   logic        zero_req;
   logic        mode_ok;
   logic [3:0]  nk_new, nr_new;
   logic [31:0] prev, sub_in, sub_out, temp;

`ifdef KEYEXP_ZEROIZE_EN
   assign zero_req = zeroize;
`else
   assign zero_req = 1'b0;
`endif

   always_comb begin
      mode_ok = 1'b0;
      nk_new  = 4'd4;
      nr_new  = 4'd10;
      case (key_mode)
         2'b00: mode_ok = 1'b1;
         2'b01: begin mode_ok = (MAX_KEY_BITS >= 192); nk_new = 4'd6; nr_new = 4'd12; end
         2'b10: begin mode_ok = (MAX_KEY_BITS >= 256); nk_new = 4'd8; nr_new = 4'd14; end
         default: mode_ok = 1'b0;
      endcase
   end

   // pos tracks idx mod Nk so no divider is needed
   assign prev      = w[idx - 6'd1];
   assign sub_in    = (pos == 4'd0) ? {prev[23:0], prev[31:24]} : prev;
   assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
   end

   always_comb begin
      temp = prev;
      if (pos == 4'd0)
         temp = sub_out ^ {rcon, 24'h000000};
      else if (nk == 4'd8 && pos == 4'd4)
         temp = sub_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         key_valid <= 1'b0;
         err       <= 1'b0;
         idx       <= '0;
         last      <= '0;
         nk        <= '0;
         nr        <= '0;
         pos       <= '0;
         rcon      <= '0;
         for (int k = 0; k < MAX_WORDS; k++) w[k] <= '0;
      end else if (zero_req) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         key_valid <= 1'b0;
         err       <= 1'b0;
         idx       <= '0;
         pos       <= '0;
         rcon      <= '0;
         for (int k = 0; k < MAX_WORDS; k++) w[k] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && mode_ok) begin
                  state     <= EXPAND;
                  busy      <= 1'b1;
                  key_valid <= 1'b0;
                  err       <= 1'b0;
                  nk        <= nk_new;
                  nr        <= nr_new;
                  idx       <= {2'b00, nk_new};
                  last      <= {nr_new, 2'b11};
                  pos       <= '0;
                  rcon      <= 8'h01;
                  for (int k = 0; k < MAX_NK; k++)
                     if (k < int'(nk_new)) w[k] <= key_in[MAX_KEY_BITS-1-32*k -: 32];
               end else if (start) begin
                  err <= 1'b1;
               end
            end
            EXPAND: begin
               w[idx] <= w[idx - {2'b00, nk}] ^ temp;
               idx    <= idx + 6'd1;
               pos    <= (pos == nk - 4'd1) ? 4'd0 : pos + 4'd1;
               if (pos == 4'd0) rcon <= rcon_next;
               if (idx == last) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  key_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd_key = '0;
      if (rd_round <= nr)
         rd_key = {w[{rd_round, 2'b00}], w[{rd_round, 2'b01}],
                   w[{rd_round, 2'b10}], w[{rd_round, 2'b11}]};
   end
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using the FIPS-197 key-expansion vectors.
module tb_aes_key_expander;
   logic         clk = 1'b0;
   logic         rst_n;
`ifdef KEYEXP_ZEROIZE_EN
   logic         zeroize;
`endif
   logic         start;
   logic [1:0]   key_mode;
   logic [255:0] key_in;
   logic         busy, done, key_valid, err;
   logic [3:0]   rd_round;
   logic [127:0] rd_key;

   int pass_cnt  = 0;
   int total_cnt = 0;

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KEYALT = {8{32'hdeadbeef}};
   localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] R192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
   localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] R256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
   localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

   always #5 clk = ~clk;

   aes_key_expander #(.MAX_KEY_BITS(256)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef KEYEXP_ZEROIZE_EN
      .zeroize   (zeroize),
`endif
      .start     (start),
      .key_mode  (key_mode),
      .key_in    (key_in),
      .busy      (busy),
      .done      (done),
      .key_valid (key_valid),
      .err       (err),
      .rd_round  (rd_round),
      .rd_key    (rd_key)
   );

   task automatic launch(input logic [1:0] mode, input logic [255:0] key);
      key_mode = mode;
      key_in   = key;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; key_mode = 2'b00; key_in = '0; rd_round = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
      zeroize = 1'b0;
`endif
      #12;
      total_cnt++;
      if ({busy, done, key_valid, err} !== 4'b0000)
         $display("FAIL reset_flags: got %b expected 0000", {busy, done, key_valid, err});
      else pass_cnt++;
      total_cnt++;
      if (rd_key !== 128'h0) $display("FAIL reset_rdkey: got %h expected 0", rd_key);
      else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_aes128;
      int cyc;
      launch(2'b00, KEY128);
      total_cnt++;
      if ({busy, key_valid} !== 2'b10) $display("FAIL a128_started: got %b expected 10", {busy, key_valid});
      else pass_cnt++;
      wait_done(cyc);
      total_cnt++;
      if (cyc !== 40) $display("FAIL a128_latency: got %0d expected 40", cyc);
      else pass_cnt++;
      total_cnt++;
      if ({busy, key_valid} !== 2'b01) $display("FAIL a128_complete: got %b expected 01", {busy, key_valid});
      else pass_cnt++;
      rd_round = 4'd0; #1;
      total_cnt++;
      if (rd_key !== R128_0) $display("FAIL a128_round0: got %h expected %h", rd_key, R128_0);
      else pass_cnt++;
      rd_round = 4'd1; #1;
      total_cnt++;
      if (rd_key !== R128_1) $display("FAIL a128_round1: got %h expected %h", rd_key, R128_1);
      else pass_cnt++;
      rd_round = 4'd10; #1;
      total_cnt++;
      if (rd_key !== R128_10) $display("FAIL a128_round10: got %h expected %h", rd_key, R128_10);
      else pass_cnt++;
      rd_round = 4'd11; #1;
      total_cnt++;
      if (rd_key !== 128'h0) $display("FAIL a128_round11: got %h expected 0", rd_key);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL a128_done_pulse: got %b expected 0", done);
      else pass_cnt++;
   endtask

   task automatic test_aes192;
      int cyc;
      launch(2'b01, KEY192);
      wait_done(cyc);
      total_cnt++;
      if (cyc !== 46) $display("FAIL a192_latency: got %0d expected 46", cyc);
      else pass_cnt++;
      rd_round = 4'd1; #1;
      total_cnt++;
      if (rd_key !== R192_1) $display("FAIL a192_round1: got %h expected %h", rd_key, R192_1);
      else pass_cnt++;
      rd_round = 4'd12; #1;
      total_cnt++;
      if (rd_key !== R192_12) $display("FAIL a192_round12: got %h expected %h", rd_key, R192_12);
      else pass_cnt++;
      rd_round = 4'd13; #1;
      total_cnt++;
      if (rd_key !== 128'h0) $display("FAIL a192_round13: got %h expected 0", rd_key);
      else pass_cnt++;
   endtask

   task automatic test_aes256;
      int cyc;
      launch(2'b10, KEY256);
      wait_done(cyc);
      total_cnt++;
      if (cyc !== 52) $display("FAIL a256_latency: got %0d expected 52", cyc);
      else pass_cnt++;
      rd_round = 4'd2; #1;
      total_cnt++;
      if (rd_key !== R256_2) $display("FAIL a256_round2: got %h expected %h", rd_key, R256_2);
      else pass_cnt++;
      rd_round = 4'd14; #1;
      total_cnt++;
      if (rd_key !== R256_14) $display("FAIL a256_round14: got %h expected %h", rd_key, R256_14);
      else pass_cnt++;
      rd_round = 4'd15; #1;
      total_cnt++;
      if (rd_key !== 128'h0) $display("FAIL a256_round15: got %h expected 0", rd_key);
      else pass_cnt++;
   endtask

   task automatic test_invalid_mode;
      int cyc;
      launch(2'b11, KEYALT);
      total_cnt++;
      if ({err, busy, key_valid} !== 3'b101)
         $display("FAIL bad_mode_flags: got %b expected 101", {err, busy, key_valid});
      else pass_cnt++;
      rd_round = 4'd14; #1;
      total_cnt++;
      if (rd_key !== R256_14) $display("FAIL bad_mode_store: got %h expected %h", rd_key, R256_14);
      else pass_cnt++;
      launch(2'b00, KEY128);
      total_cnt++;
      if ({err, busy} !== 2'b01) $display("FAIL bad_mode_clear: got %b expected 01", {err, busy});
      else pass_cnt++;
      wait_done(cyc);
   endtask

   task automatic test_back_to_back;
      int cyc;
      total_cnt++;
      if (done !== 1'b1) $display("FAIL b2b_done_now: got %b expected 1", done);
      else pass_cnt++;
      launch(2'b01, KEY192);
      total_cnt++;
      if ({busy, key_valid} !== 2'b10) $display("FAIL b2b_started: got %b expected 10", {busy, key_valid});
      else pass_cnt++;
      wait_done(cyc);
      rd_round = 4'd12; #1;
      total_cnt++;
      if (cyc !== 46 || rd_key !== R192_12)
         $display("FAIL b2b_result: got cyc=%0d key=%h expected cyc=46 key=%h", cyc, rd_key, R192_12);
      else pass_cnt++;
   endtask

   task automatic test_restart_ignored;
      int cyc;
      launch(2'b00, KEY128);
      cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin
         start    = (cyc == 9);
         key_mode = 2'b01;
         key_in   = KEYALT;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      total_cnt++;
      if (cyc !== 40 || err !== 1'b0) $display("FAIL restart_latency: got cyc=%0d err=%b expected 40 0", cyc, err);
      else pass_cnt++;
      rd_round = 4'd10; #1;
      total_cnt++;
      if (rd_key !== R128_10) $display("FAIL restart_round10: got %h expected %h", rd_key, R128_10);
      else pass_cnt++;
   endtask

   task automatic test_abort;
      launch(2'b00, KEY128);
      repeat (19) begin @(posedge clk); #1; end
      rd_round = 4'd0;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({busy, key_valid, done} !== 3'b000)
         $display("FAIL abort_flags: got %b expected 000", {busy, key_valid, done});
      else pass_cnt++;
      total_cnt++;
      if (rd_key !== 128'h0) $display("FAIL abort_rdkey: got %h expected 0", rd_key);
      else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if ({busy, key_valid} !== 2'b00) $display("FAIL abort_stays_idle: got %b expected 00", {busy, key_valid});
      else pass_cnt++;
   endtask

`ifdef KEYEXP_ZEROIZE_EN
   task automatic test_zeroize;
      int  cyc;
      logic nonzero;
      launch(2'b10, KEY256);
      wait_done(cyc);
      zeroize = 1'b1;
      launch(2'b00, KEY128);
      zeroize = 1'b0;
      total_cnt++;
      if ({busy, key_valid} !== 2'b00) $display("FAIL zeroize_flags: got %b expected 00", {busy, key_valid});
      else pass_cnt++;
      nonzero = 1'b0;
      for (int r = 0; r < 16; r++) begin
         rd_round = 4'(r); #1;
         if (rd_key !== 128'h0) nonzero = 1'b1;
      end
      total_cnt++;
      if (nonzero !== 1'b0) $display("FAIL zeroize_store: got nonzero round key expected all 0");
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_aes128();
      test_aes192();
      test_aes256();
      test_invalid_mode();
      test_back_to_back();
      test_restart_ignored();
      test_abort();
`ifdef KEYEXP_ZEROIZE_EN
      test_zeroize();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
